// File: rtl/vending_pkg.sv
// Shared constants for the vending controller: coin codes and values, default prices,
// the coin-frame state encoding and 7-segment patterns.
package vending_pkg;

  localparam logic [1:0] CODE_BAD = 2'b00;
  localparam logic [1:0] CODE_5   = 2'b01;
  localparam logic [1:0] CODE_10  = 2'b10;
  localparam logic [1:0] CODE_25  = 2'b11;

  localparam logic [6:0] COIN_5  = 7'd5;
  localparam logic [6:0] COIN_10 = 7'd10;
  localparam logic [6:0] COIN_25 = 7'd25;

  localparam int DEF_PRICE_A    = 15;
  localparam int DEF_PRICE_B    = 20;
  localparam int DEF_PRICE_C    = 30;
  localparam int DEF_PRICE_D    = 45;
  localparam int DEF_CREDIT_MAX = 99;

  typedef enum logic [1:0] {IDLE, C1, C0, STOP} frame_state_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_R = 7'h50;

  // Credit never exceeds 99, so both digits fit in 4 bits.
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to 7-segment {g,f,e,d,c,b,a}, active-high; non-BCD input blanks the digit.
module seg7_decoder
  import vending_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/vending_machine.sv
// Coin-frame decoder, saturating credit register and edge-triggered vend logic,
// with a two-digit display of the credit or "Er" after a refused purchase.
module vending_machine
  import vending_pkg::*;
#(
  parameter int PRICE_A    = DEF_PRICE_A,
  parameter int PRICE_B    = DEF_PRICE_B,
  parameter int PRICE_C    = DEF_PRICE_C,
  parameter int PRICE_D    = DEF_PRICE_D,
  parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serialIn,
  input  logic       buy,
  input  logic [1:0] product,
  output logic [6:0] digit1,
  output logic [6:0] digit0
);

  localparam logic [6:0] CMAX = 7'(CREDIT_MAX);

  frame_state_e state_q, state_d;
  logic [1:0]   code_q, code_d;
  logic [6:0]   credit_q, credit_d;
  logic         error_q, error_d;
  logic         buy_q;

  logic [6:0] coin_val, price;
  logic [7:0] sum;
  logic       vend_req, vend_ok;
  logic [6:0] seg1, seg0;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    coin_val = 7'd0;
    case (state_q)
      IDLE: if (!serialIn) state_d = C1;
      C1: begin
        code_d[1] = serialIn;
        state_d   = C0;
      end
      C0: begin
        code_d[0] = serialIn;
        state_d   = STOP;
      end
      STOP: begin
        state_d = IDLE;
        // Bad stop bit or code 00 drops the frame without a trace.
        if (serialIn) begin
          case (code_q)
            CODE_5:  coin_val = COIN_5;
            CODE_10: coin_val = COIN_10;
            CODE_25: coin_val = COIN_25;
            default: coin_val = 7'd0;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    price = 7'(PRICE_A);
    case (product)
      2'b00: price = 7'(PRICE_A);
      2'b01: price = 7'(PRICE_B);
      2'b10: price = 7'(PRICE_C);
      2'b11: price = 7'(PRICE_D);
      default: price = 7'(PRICE_A);
    endcase
  end

  assign vend_req = buy & ~buy_q;
  // Price check against the pre-update credit, so a same-cycle coin cannot fund this vend.
  assign vend_ok  = vend_req && (credit_q >= price);
  assign sum      = 8'(credit_q) + 8'(coin_val) - (vend_ok ? 8'(price) : 8'd0);

  always_comb begin
    credit_d = (sum > 8'(CMAX)) ? CMAX : sum[6:0];
    error_d  = error_q;
    if (vend_req)             error_d = ~vend_ok;
    else if (coin_val != '0)  error_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      code_q   <= CODE_BAD;
      credit_q <= 7'd0;
      error_q  <= 1'b0;
      buy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      credit_q <= credit_d;
      error_q  <= error_d;
      buy_q    <= buy;
    end
  end

  seg7_decoder u_dec_tens (.bcd_i(tens_of(credit_q)), .seg_o(seg1));
  seg7_decoder u_dec_ones (.bcd_i(ones_of(credit_q)), .seg_o(seg0));

  assign digit1 = error_q ? SEG_E : seg1;
  assign digit0 = error_q ? SEG_R : seg0;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench: stimulus queues expected display values, a negedge monitor pops and compares.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       buy;
  logic [1:0] product;
  logic [6:0] digit1, digit0;

  typedef struct {
    string      name;
    logic [6:0] d1;
    logic [6:0] d0;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  vending_machine dut (
    .clk(clk), .reset(reset), .serialIn(serialIn), .buy(buy),
    .product(product), .digit1(digit1), .digit0(digit0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic expect_num(input string name, input int c);
    exp_t e;
    e.name = name;
    e.d1 = seg(c / 10);
    e.d0 = seg(c % 10);
    q.push_back(e);
  endtask

  task automatic expect_err(input string name);
    exp_t e;
    e.name = name;
    e.d1 = 7'h79;
    e.d0 = 7'h50;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bits[3] goes out first; optionally raise buy together with the stop bit.
  task automatic send_frame(input logic [3:0] bits, input logic buy_at_stop);
    for (int i = 3; i >= 0; i--) begin
      serialIn = bits[i];
      if (i == 0 && buy_at_stop) buy = 1'b1;
      tick();
    end
    serialIn = 1'b1;
  endtask

  task automatic do_buy(input logic [1:0] p);
    product = p;
    buy = 1'b1;
    tick();
    buy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (digit1 !== e.d1 || digit0 !== e.d0) begin
          bad++;
          $display("FAIL %s: got %h,%h want %h,%h", e.name, digit1, digit0, e.d1, e.d0);
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; serialIn = 1'b1; buy = 1'b0; product = 2'b00;
    do_reset();
    expect_num("reset", 0);
    tick(); tick();
    expect_num("idle", 0);

    send_frame(4'b0111, 1'b0);
    expect_num("coin25", 25);
    do_buy(2'b00);
    expect_num("buy_apple", 10);

    tick();
    do_buy(2'b11);
    expect_err("buy_date_short");
    tick(); tick();
    expect_err("err_holds");
    send_frame(4'b0011, 1'b0);
    expect_num("coin5_clears_err", 15);

    send_frame(4'b0100, 1'b0);
    expect_num("bad_stop", 15);
    send_frame(4'b0001, 1'b0);
    expect_num("code00", 15);
    send_frame(4'b0101, 1'b0);
    expect_num("b2b_first", 25);
    send_frame(4'b0101, 1'b0);
    expect_num("b2b_second", 35);

    do_reset();
    expect_num("reset2", 0);
    send_frame(4'b0111, 1'b0); expect_num("sat1", 25);
    send_frame(4'b0111, 1'b0); expect_num("sat2", 50);
    send_frame(4'b0111, 1'b0); expect_num("sat3", 75);
    send_frame(4'b0111, 1'b0); expect_num("sat4", 99);
    send_frame(4'b0111, 1'b0); expect_num("sat5", 99);
    product = 2'b01;
    buy = 1'b1;
    tick(); expect_num("held_buy1", 79);
    tick(); expect_num("held_buy2", 79);
    tick(); expect_num("held_buy3", 79);
    buy = 1'b0;
    tick();
    do_buy(2'b11);
    expect_num("buy_date_ok", 34);

    // Reset lands on the C0-sample edge of a 25c frame.
    serialIn = 1'b0; tick();
    serialIn = 1'b1; tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    expect_num("reset_mid_frame", 0);
    tick(); tick(); tick();
    expect_num("no_late_coin", 0);

    send_frame(4'b0101, 1'b0);
    send_frame(4'b0011, 1'b0);
    expect_num("credit15", 15);
    product = 2'b00;
    send_frame(4'b0101, 1'b1);
    buy = 1'b0;
    expect_num("coin_and_buy", 10);
    tick();
    do_buy(2'b00);
    expect_err("buy_after_coin_vend");

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
